// File: rtl/risc16_alu_arbiter_pkg.sv
// Shared ALU opcode and arbiter state encodings for the two-port RiSC16 ALU arbiter.
package risc16_alu_arbiter_pkg;

  localparam int ALU_FUNCT_LEN = 2;

  localparam logic [ALU_FUNCT_LEN-1:0] ALU_ADD   = 2'd0;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_NAND  = 2'd1;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_PASSA = 2'd2;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_SUB   = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/risc16_alu_arbiter_alu.sv
// RiSC16 ALU: purely combinational add/nand/pass/sub with a zero flag.
module risc16_alu_arbiter_alu #(
  parameter int WORD_LENGTH   = 16,
  parameter int ALU_FUNCT_LEN = risc16_alu_arbiter_pkg::ALU_FUNCT_LEN
) (
  input  logic [WORD_LENGTH-1:0]   src1,
  input  logic [WORD_LENGTH-1:0]   src2,
  input  logic [ALU_FUNCT_LEN-1:0] funct,
  output logic [WORD_LENGTH-1:0]   result,
  output logic                     zero
);
  import risc16_alu_arbiter_pkg::*;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result = '0;
    case (funct)
      ALU_ADD:   result = src1 + src2;
      ALU_NAND:  result = ~(src1 & src2);
      ALU_PASSA: result = src1;
      ALU_SUB:   result = src1 - src2;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/risc16_alu_arbiter.sv
// Round-robin arbiter sharing one RiSC16 ALU between two requesters with a registered response.
module risc16_alu_arbiter #(
  parameter int WORD_LENGTH   = 16,
  parameter int ALU_FUNCT_LEN = risc16_alu_arbiter_pkg::ALU_FUNCT_LEN
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [WORD_LENGTH-1:0]   req_src1_0,
  input  logic [WORD_LENGTH-1:0]   req_src2_0,
  input  logic [ALU_FUNCT_LEN-1:0] req_funct_0,
  input  logic [WORD_LENGTH-1:0]   req_src1_1,
  input  logic [WORD_LENGTH-1:0]   req_src2_1,
  input  logic [ALU_FUNCT_LEN-1:0] req_funct_1,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [WORD_LENGTH-1:0]   rsp_result,
  output logic                     rsp_zero,
  output logic                     busy,
  output logic [WORD_LENGTH-1:0]   op_count
);
  import risc16_alu_arbiter_pkg::*;

  arb_state_e               state_q, state_d;
  logic                     last_grant_q;
  logic                     grant;
  logic                     grant_valid;
  logic                     accept;
  logic [WORD_LENGTH-1:0]   src1_q, src2_q;
  logic [ALU_FUNCT_LEN-1:0] funct_q;
  logic                     id_q;
  logic [WORD_LENGTH-1:0]   rsp_result_q;
  logic                     rsp_zero_q;
  logic [WORD_LENGTH-1:0]   op_count_q;
  logic [WORD_LENGTH-1:0]   alu_result;
  logic                     alu_zero;

  // Tie goes to whichever port did not win last time.
  always_comb begin
    grant_valid = |req_valid;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
  end

  assign accept = (state_q == ARB_IDLE) && grant_valid;

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (grant_valid) state_d = ARB_EXEC;
      ARB_EXEC: state_d = ARB_RESP;
      ARB_RESP: if (rsp_ready) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (accept) req_ready[grant] = 1'b1;
    busy      = (state_q != ARB_IDLE);
    rsp_valid = (state_q == ARB_RESP);
  end

  // NOTE: all datapath registers are reset so a mid-operation reset leaves no stale response visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      src1_q       <= '0;
      src2_q       <= '0;
      funct_q      <= '0;
      id_q         <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      if (accept) begin
        src1_q       <= grant ? req_src1_1  : req_src1_0;
        src2_q       <= grant ? req_src2_1  : req_src2_0;
        funct_q      <= grant ? req_funct_1 : req_funct_0;
        id_q         <= grant;
        last_grant_q <= grant;
      end
      if (state_q == ARB_EXEC) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
      end
      if ((state_q == ARB_RESP) && rsp_ready)
        op_count_q <= op_count_q + WORD_LENGTH'(1);
    end
  end

  risc16_alu_arbiter_alu #(
    .WORD_LENGTH  (WORD_LENGTH),
    .ALU_FUNCT_LEN(ALU_FUNCT_LEN)
  ) u_alu (
    .src1  (src1_q),
    .src2  (src2_q),
    .funct (funct_q),
    .result(alu_result),
    .zero  (alu_zero)
  );

  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_risc16_alu_arbiter.sv
// Directed bench for risc16_alu_arbiter: latency, ALU ops, fairness, backpressure, reset and op_count wrap.
module tb_risc16_alu_arbiter;
  import risc16_alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req_src1_0, req_src2_0, req_src1_1, req_src2_1;
  logic [1:0]  req_funct_0, req_funct_1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [15:0] rsp_result, op_count;

  // Narrow instance: op_count wraps after 16 acknowledges.
  logic [1:0]  s_req_valid, s_req_ready;
  logic [3:0]  s_src1_0, s_src2_0, s_src1_1, s_src2_1;
  logic [1:0]  s_funct_0, s_funct_1;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_id, s_rsp_zero, s_busy;
  logic [3:0]  s_rsp_result, s_op_count;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_count;

  always #5 clk = ~clk;

  risc16_alu_arbiter #(.WORD_LENGTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1_0(req_src1_0), .req_src2_0(req_src2_0), .req_funct_0(req_funct_0),
    .req_src1_1(req_src1_1), .req_src2_1(req_src2_1), .req_funct_1(req_funct_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
  );

  risc16_alu_arbiter #(.WORD_LENGTH(4)) dut_small (
    .clk(clk), .reset_n(reset_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_src1_0(s_src1_0), .req_src2_0(s_src2_0), .req_funct_0(s_funct_0),
    .req_src1_1(s_src1_1), .req_src2_1(s_src2_1), .req_funct_1(s_funct_1),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
    .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero), .busy(s_busy), .op_count(s_op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one time unit after a rising edge, in IDLE, with the request inputs already driven.
  task automatic txn(input logic [1:0] exp_ready, input logic exp_id,
                     input logic [15:0] exp_res, input logic exp_zero);
    #1;
    check("req_ready_grant", 32'(req_ready), 32'(exp_ready));
    check("busy_idle", 32'(busy), 32'd0);
    tick();
    check("busy_exec", 32'(busy), 32'd1);
    check("rsp_valid_exec", 32'(rsp_valid), 32'd0);
    check("req_ready_exec", 32'(req_ready), 32'd0);
    tick();
    check("rsp_valid_resp", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(exp_id));
    check("rsp_result", 32'(rsp_result), 32'(exp_res));
    check("rsp_zero", 32'(rsp_zero), 32'(exp_zero));
    tick();
    exp_count = exp_count + 16'd1;
    check("op_count", 32'(op_count), 32'(exp_count));
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    exp_count = 16'd0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 1'b0;
    req_src1_0 = '0; req_src2_0 = '0; req_funct_0 = '0;
    req_src1_1 = '0; req_src2_1 = '0; req_funct_1 = '0;
    s_req_valid = 2'b00; s_rsp_ready = 1'b0;
    s_src1_0 = '0; s_src2_0 = '0; s_funct_0 = '0;
    s_src1_1 = '0; s_src2_1 = '0; s_funct_1 = '0;
    exp_count = 16'd0;

    #3;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_result", 32'(rsp_result), 32'd0);
    check("reset_rsp_zero", 32'(rsp_zero), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    apply_reset();

    // Single-port operations.
    rsp_ready = 1'b1;
    req_src1_0 = 16'h0005; req_src2_0 = 16'h0003; req_funct_0 = ALU_ADD; req_valid = 2'b01;
    txn(2'b01, 1'b0, 16'h0008, 1'b0);
    req_src1_1 = 16'h0007; req_src2_1 = 16'h0007; req_funct_1 = ALU_SUB; req_valid = 2'b10;
    txn(2'b10, 1'b1, 16'h0000, 1'b1);
    req_src1_1 = 16'h0000; req_src2_1 = 16'h0001;
    txn(2'b10, 1'b1, 16'hFFFF, 1'b0);
    req_valid = 2'b00;

    // Both ports requesting continuously: grants alternate starting with port 0.
    apply_reset();
    req_src1_0 = 16'hFFFF; req_src2_0 = 16'hFFFF; req_funct_0 = ALU_NAND;
    req_src1_1 = 16'h1234; req_src2_1 = 16'hABCD; req_funct_1 = ALU_PASSA;
    req_valid = 2'b11;
    txn(2'b01, 1'b0, 16'h0000, 1'b1);
    txn(2'b10, 1'b1, 16'h1234, 1'b0);
    txn(2'b01, 1'b0, 16'h0000, 1'b1);
    txn(2'b10, 1'b1, 16'h1234, 1'b0);
    req_valid = 2'b00;

    // Backpressure: response held while port 1 waits.
    rsp_ready = 1'b0;
    req_src1_0 = 16'h00FF; req_src2_0 = 16'h0001; req_funct_0 = ALU_ADD; req_valid = 2'b01;
    #1;
    check("bp_req_ready_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b10;
    #1;
    check("bp_req_ready_exec", 32'(req_ready), 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_id", 32'(rsp_id), 32'd0);
      check("bp_rsp_result", 32'(rsp_result), 32'h0100);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      check("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    exp_count = exp_count + 16'd1;
    check("bp_op_count", 32'(op_count), 32'(exp_count));
    txn(2'b10, 1'b1, 16'h1234, 1'b0);
    req_valid = 2'b00;

    // Reset during EXEC discards the operation.
    req_src1_0 = 16'h0001; req_src2_0 = 16'h0001; req_funct_0 = ALU_ADD; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    check("mid_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rsp_result", 32'(rsp_result), 32'd0);
    check("mid_op_count", 32'(op_count), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    exp_count = 16'd0;
    tick();
    tick();
    check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    check("mid_idle", 32'(busy), 32'd0);
    req_src1_1 = 16'h1234; req_funct_1 = ALU_PASSA; req_valid = 2'b11;
    txn(2'b01, 1'b0, 16'h0002, 1'b0);
    txn(2'b10, 1'b1, 16'h1234, 1'b0);
    req_valid = 2'b00;

    // op_count wrap on the narrow instance; 9+8 also wraps the 4-bit adder.
    s_src1_0 = 4'h9; s_src2_0 = 4'h8; s_funct_0 = ALU_ADD;
    s_rsp_ready = 1'b1; s_req_valid = 2'b01;
    for (int i = 0; i < 45; i++) tick();
    check("wrap_count_15", 32'(s_op_count), 32'hF);
    for (int i = 0; i < 3; i++) tick();
    check("wrap_count_0", 32'(s_op_count), 32'h0);
    tick();
    tick();
    check("wrap_rsp_result", 32'(s_rsp_result), 32'h1);
    check("wrap_rsp_zero", 32'(s_rsp_zero), 32'd0);
    tick();
    s_req_valid = 2'b00;
    check("wrap_count_1", 32'(s_op_count), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
